// File: rtl/dynamic_node_header_decode.sv
// ============================================================================
// dynamic_node_header_decode: one-entry flit stage that tracks head/body/tail
// framing and holds the destination fields of the packet in flight.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dynamic_node_header_decode #(
  parameter int DATA_WIDTH  = 64,
  parameter int CHIP_WIDTH  = 14,
  parameter int XY_WIDTH    = 8,
  parameter int FBITS_WIDTH = 4,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_head,
  output logic                   out_tail,
  output logic [CHIP_WIDTH-1:0]  dest_chip,
  output logic [XY_WIDTH-1:0]    dest_x,
  output logic [XY_WIDTH-1:0]    dest_y,
  output logic [FBITS_WIDTH-1:0] dest_fbits,
  output logic                   route_valid
);

  // Header fields are packed downward from the MSB: chip, x, y, fbits, len.
  localparam int CHIP_LSB = DATA_WIDTH - CHIP_WIDTH;
  localparam int X_LSB    = CHIP_LSB - XY_WIDTH;
  localparam int Y_LSB    = X_LSB - XY_WIDTH;
  localparam int FB_LSB   = Y_LSB - FBITS_WIDTH;
  localparam int LEN_LSB  = FB_LSB - LEN_WIDTH;

  typedef enum logic [0:0] {
    ST_HEAD = 1'b0,
    ST_BODY = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_head_q, out_head_d;
  logic                   out_tail_q, out_tail_d;
  logic [CHIP_WIDTH-1:0]  dest_chip_q, dest_chip_d;
  logic [XY_WIDTH-1:0]    dest_x_q, dest_x_d;
  logic [XY_WIDTH-1:0]    dest_y_q, dest_y_d;
  logic [FBITS_WIDTH-1:0] dest_fbits_q, dest_fbits_d;
  logic                   route_valid_q, route_valid_d;

  logic                   w_accept;
  logic                   w_emit;
  logic [LEN_WIDTH-1:0]   w_len;

  assign in_ready = !out_valid_q || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_emit   = out_valid_q && out_ready;
  assign w_len    = in_data[LEN_LSB +: LEN_WIDTH];

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_head_d    = out_head_q;
    out_tail_d    = out_tail_q;
    dest_chip_d   = dest_chip_q;
    dest_x_d      = dest_x_q;
    dest_y_d      = dest_y_q;
    dest_fbits_d  = dest_fbits_q;
    route_valid_d = route_valid_q;

    if (w_emit) begin
      out_valid_d = 1'b0;
      if (out_tail_q) begin
        route_valid_d = 1'b0;
      end
    end

    // An accept on the same edge as an emit overrides the clears above.
    if (w_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      case (state_q)
        ST_HEAD: begin
          dest_chip_d   = in_data[CHIP_LSB +: CHIP_WIDTH];
          dest_x_d      = in_data[X_LSB +: XY_WIDTH];
          dest_y_d      = in_data[Y_LSB +: XY_WIDTH];
          dest_fbits_d  = in_data[FB_LSB +: FBITS_WIDTH];
          route_valid_d = 1'b1;
          out_head_d    = 1'b1;
          count_d       = w_len;
          if (w_len == '0) begin
            out_tail_d = 1'b1;
            state_d    = ST_HEAD;
          end else begin
            out_tail_d = 1'b0;
            state_d    = ST_BODY;
          end
        end
        ST_BODY: begin
          out_head_d = 1'b0;
          count_d    = count_q - LEN_WIDTH'(1);
          if (count_q == LEN_WIDTH'(1)) begin
            out_tail_d = 1'b1;
            state_d    = ST_HEAD;
          end else begin
            out_tail_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_HEAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_HEAD;
      count_q       <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_head_q    <= 1'b0;
      out_tail_q    <= 1'b0;
      dest_chip_q   <= '0;
      dest_x_q      <= '0;
      dest_y_q      <= '0;
      dest_fbits_q  <= '0;
      route_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_head_q    <= out_head_d;
      out_tail_q    <= out_tail_d;
      dest_chip_q   <= dest_chip_d;
      dest_x_q      <= dest_x_d;
      dest_y_q      <= dest_y_d;
      dest_fbits_q  <= dest_fbits_d;
      route_valid_q <= route_valid_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_head    = out_head_q;
  assign out_tail    = out_tail_q;
  assign dest_chip   = dest_chip_q;
  assign dest_x      = dest_x_q;
  assign dest_y      = dest_y_q;
  assign dest_fbits  = dest_fbits_q;
  assign route_valid = route_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_dynamic_node_header_decode.sv
// ============================================================================
// tb_dynamic_node_header_decode: packet-level scoreboard bench.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dynamic_node_header_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_head;
  logic        out_tail;
  logic [13:0] dest_chip;
  logic [7:0]  dest_x;
  logic [7:0]  dest_y;
  logic [3:0]  dest_fbits;
  logic        route_valid;

  always #5 clk = ~clk;

  dynamic_node_header_decode #(
    .DATA_WIDTH(64), .CHIP_WIDTH(14), .XY_WIDTH(8), .FBITS_WIDTH(4), .LEN_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_head(out_head), .out_tail(out_tail),
    .dest_chip(dest_chip), .dest_x(dest_x), .dest_y(dest_y), .dest_fbits(dest_fbits),
    .route_valid(route_valid)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        head;
    logic        tail;
    logic [13:0] chip;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [3:0]  fb;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   heads_acc  = 0;
  int   tails_emit = 0;
  logic drv_is_head = 1'b0;
  int   ready_mode = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: 0 = always ready, 1 = random stalls, 2 = fully stalled.
  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(99) >= 30);
      default: out_ready = 1'b0;
    endcase
  end

  // A packet is routable from its head being accepted until its tail leaves.
  always @(negedge clk) begin
    if (!reset) begin
      check("route_valid", 128'(route_valid), 128'(heads_acc > tails_emit));
      check("in_ready", 128'(in_ready), 128'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_flit: got %0h expected no flit", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_data", 128'(out_data), 128'(mon_e.data));
          check("head_tail", 128'({out_head, out_tail}), 128'({mon_e.head, mon_e.tail}));
          check("dest", 128'({dest_chip, dest_x, dest_y, dest_fbits}),
                128'({mon_e.chip, mon_e.x, mon_e.y, mon_e.fb}));
          if (mon_e.tail) tails_emit++;
        end
      end
      if (in_valid && in_ready && drv_is_head) heads_acc++;
    end
  end

  task automatic send_packet(input logic [13:0] chip, input logic [7:0] x, input logic [7:0] y,
                             input logic [3:0] fb, input int len, input int n_send,
                             input int gap_pct);
    int nfl;
    int waits;
    exp_t e;
    logic [63:0] d;
    nfl = len + 1;
    if (n_send > 0 && n_send < nfl) nfl = n_send;
    for (int i = 0; i < nfl; i++) begin
      d = {$urandom, $urandom};
      if (i == 0) d[63:22] = {chip, x, y, fb, 8'(len)};
      e.data = d;
      e.head = (i == 0);
      e.tail = (i == len);
      e.chip = chip;
      e.x    = x;
      e.y    = y;
      e.fb   = fb;
      @(posedge clk); #1;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid    = 1'b1;
      in_data     = d;
      drv_is_head = (i == 0);
      waits = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        waits++;
        if (waits > 2000) begin
          n_checks++;
          n_fail++;
          $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected accept", waits);
          return;
        end
        @(posedge clk); #1;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    in_valid    = 1'b0;
    drv_is_head = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_valid) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d flits pending expected 0", exp_q.size());
    end
  endtask

  task automatic check_zeroed(input string tag);
    check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_route_valid"}, 128'(route_valid), 128'(0));
    check({tag, "_flags"}, 128'({out_head, out_tail}), 128'(0));
    check({tag, "_out_data"}, 128'(out_data), 128'(0));
    check({tag, "_dest"}, 128'({dest_chip, dest_x, dest_y, dest_fbits}), 128'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zeroed("reset");
    @(posedge clk); #2 reset = 1'b0;

    // Single-flit packet: head and tail at once, route drops after emit.
    send_packet(14'd3, 8'd2, 8'd5, 4'h1, 0, 0, 0);
    go_idle();
    wait_drain();

    // Back-to-back packets, including tail-emit coinciding with a new head.
    send_packet(14'd9, 8'd4, 8'd6, 4'h2, 3, 0, 0);
    send_packet(14'd9, 8'd7, 8'd1, 4'h3, 2, 0, 0);
    send_packet(14'd1, 8'd7, 8'd7, 4'h4, 0, 0, 0);
    go_idle();
    wait_drain();

    // Downstream stall in the middle of a packet.
    fork
      send_packet(14'd5, 8'd3, 8'd3, 4'h5, 3, 0, 0);
      begin
        repeat (3) @(posedge clk);
        ready_mode = 2;
        repeat (5) @(posedge clk);
        ready_mode = 0;
      end
    join
    go_idle();
    wait_drain();

    // Reset in the middle of a len=4 packet, then a fresh head.
    send_packet(14'd2, 8'd9, 8'd9, 4'h6, 4, 3, 0);
    @(posedge clk); #1;
    in_valid    = 1'b0;
    drv_is_head = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_zeroed("midreset");
    exp_q.delete();
    heads_acc  = 0;
    tails_emit = 0;
    @(posedge clk); #2 reset = 1'b0;
    send_packet(14'd8, 8'd1, 8'd2, 4'h7, 1, 0, 0);
    go_idle();
    wait_drain();

    // Maximum-length packet.
    send_packet(14'h3fff, 8'hff, 8'hfe, 4'hf, 255, 0, 0);
    go_idle();
    wait_drain();

    // Random traffic with input bubbles and output backpressure.
    ready_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = ($urandom_range(9) == 0) ? int'($urandom_range(40)) : int'($urandom_range(5));
      send_packet(14'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), len, 0, 25);
    end
    go_idle();
    ready_mode = 0;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
